// File: rtl/lcd_controlador_if.sv
// Content-generator side of the HD44780 controller: write request, busy
// back-pressure and the registered LCD pins.
interface lcd_controlador_if;
  logic       lcd_enable;
  logic [9:0] lcd_bus;
  logic       busy;
  logic       rs;
  logic       rw;
  logic       e;
  logic [7:0] lcd_data;

  modport master (
    output lcd_enable, lcd_bus,
    input  busy, rs, rw, e, lcd_data
  );

  modport slave (
    input  lcd_enable, lcd_bus,
    output busy, rs, rw, e, lcd_data
  );
endinterface

// File: rtl/lcd_controlador.sv
// HD44780 8-bit write controller: power-up wait, init sequence, then single writes.
// Define LCD_SIM_FAST_EN to shrink the 50 ms / 2 ms waits for simulation.
module lcd_controlador #(
  parameter int CLK_FREQ_MHZ = 50
) (
  input  logic              clk,
  input  logic              rst,
  lcd_controlador_if.slave  bus
);

  typedef enum logic [1:0] {POWER_UP, INIT, READY, SEND} state_t;

  localparam logic [23:0] U_CYC     = 24'(CLK_FREQ_MHZ);
  localparam logic [23:0] E_END_CYC = 24'(14 * CLK_FREQ_MHZ);
  localparam logic [23:0] SHORT_CYC = 24'(50 * CLK_FREQ_MHZ);
`ifdef LCD_SIM_FAST_EN
  localparam logic [23:0] PWR_CYC   = 24'(10 * CLK_FREQ_MHZ);
  localparam logic [23:0] LONG_CYC  = 24'(60 * CLK_FREQ_MHZ);
`else
  localparam logic [23:0] PWR_CYC   = 24'(50000 * CLK_FREQ_MHZ);
  localparam logic [23:0] LONG_CYC  = 24'(2000 * CLK_FREQ_MHZ);
`endif

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  state_t      state;
  logic [23:0] cnt;
  logic [1:0]  init_idx;

  logic [23:0] cnt_next;
  logic        e_next;
  logic        long_cmd;
  logic        xfer_last;

  // Timing is derived from the latched pins, so INIT and SEND share one rule set.
  always_comb begin
    cnt_next  = cnt + 24'd1;
    e_next    = (cnt_next >= U_CYC) && (cnt_next < E_END_CYC);
    long_cmd  = !bus.rs && ((bus.lcd_data == 8'h01) || (bus.lcd_data == 8'h02));
    xfer_last = (cnt == ((long_cmd ? LONG_CYC : SHORT_CYC) - 24'd1));
  end

  // NOTE: every state register uses <= so all of them update from the same
  // pre-edge values; the async reset pulls e low without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= POWER_UP;
      cnt          <= '0;
      init_idx     <= '0;
      bus.busy     <= 1'b1;
      bus.e        <= 1'b0;
      bus.rs       <= 1'b0;
      bus.rw       <= 1'b0;
      bus.lcd_data <= 8'h00;
    end else begin
      case (state)
        POWER_UP: begin
          if (cnt == PWR_CYC - 24'd1) begin
            state        <= INIT;
            cnt          <= '0;
            init_idx     <= '0;
            bus.rs       <= 1'b0;
            bus.rw       <= 1'b0;
            bus.lcd_data <= init_cmd(2'd0);
          end else begin
            cnt <= cnt_next;
          end
        end

        INIT: begin
          if (xfer_last) begin
            cnt   <= '0;
            bus.e <= 1'b0;
            if (init_idx == 2'd3) begin
              state    <= READY;
              bus.busy <= 1'b0;
            end else begin
              init_idx     <= init_idx + 2'd1;
              bus.lcd_data <= init_cmd(init_idx + 2'd1);
            end
          end else begin
            cnt   <= cnt_next;
            bus.e <= e_next;
          end
        end

        READY: begin
          cnt <= '0;
          if (bus.lcd_enable) begin
            state        <= SEND;
            bus.busy     <= 1'b1;
            bus.rs       <= bus.lcd_bus[9];
            bus.rw       <= bus.lcd_bus[8];
            bus.lcd_data <= bus.lcd_bus[7:0];
          end
        end

        SEND: begin
          if (xfer_last) begin
            state    <= READY;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.e    <= 1'b0;
          end else begin
            cnt   <= cnt_next;
            bus.e <= e_next;
          end
        end

        default: begin
          state    <= POWER_UP;
          cnt      <= '0;
          bus.busy <= 1'b1;
          bus.e    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_controlador.sv
// Directed bench for lcd_controlador at CLK_FREQ_MHZ=1 (U = 1 cycle); outputs
// are sampled on the falling edge, inputs driven there too.
module tb_lcd_controlador;

  localparam int U     = 1;
  localparam int SHORT = 50 * U;
`ifdef LCD_SIM_FAST_EN
  localparam int PWR   = 10 * U;
  localparam int LONG  = 60 * U;
`else
  localparam int PWR   = 50000 * U;
  localparam int LONG  = 2000 * U;
`endif
  localparam int E_HIGH = 13 * U;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  lcd_controlador_if lcd_if ();

  lcd_controlador #(.CLK_FREQ_MHZ(U)) dut (
    .clk (clk),
    .rst (rst),
    .bus (lcd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Counts falling edges until e reaches the given level or the budget runs out.
  task automatic wait_e(input logic level, input int budget, output int n);
    n = 0;
    while (lcd_if.e !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Accepts one request, then follows the whole SEND window.
  task automatic xfer(input logic [9:0] v, input int win, input string tag);
    int n, rise_at, high, unstable;
    lcd_if.lcd_enable = 1'b1;
    lcd_if.lcd_bus    = v;
    @(negedge clk);
    lcd_if.lcd_enable = 1'b0;
    lcd_if.lcd_bus    = 10'h3FF;
    check({tag, "_busy"}, 32'(lcd_if.busy), 32'd1);
    check({tag, "_rs"},   32'(lcd_if.rs), 32'(v[9]));
    check({tag, "_rw"},   32'(lcd_if.rw), 32'(v[8]));
    check({tag, "_data"}, 32'(lcd_if.lcd_data), 32'(v[7:0]));
    n = 0; rise_at = -1; high = 0; unstable = 0;
    while (lcd_if.busy === 1'b1 && n < LONG + 100) begin
      @(negedge clk);
      n++;
      if (lcd_if.e === 1'b1) begin
        high++;
        if (rise_at < 0) rise_at = n;
      end
      if (lcd_if.rs !== v[9] || lcd_if.rw !== v[8] || lcd_if.lcd_data !== v[7:0]) unstable++;
    end
    check({tag, "_window"},   32'(n), 32'(win));
    check({tag, "_e_rise"},   32'(rise_at), 32'(U));
    check({tag, "_e_high"},   32'(high), 32'(E_HIGH));
    check({tag, "_unstable"}, 32'(unstable), 32'd0);
  endtask

  initial begin
    logic [7:0] init_cmds [4];
    int n, busy_low, rises, bad;
    logic prev_e;
    init_cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
    errors = 0;
    checks = 0;

    rst               = 1'b1;
    lcd_if.lcd_enable = 1'b0;
    lcd_if.lcd_bus    = '0;
    @(negedge clk);
    check("rst_busy", 32'(lcd_if.busy), 32'd1);
    check("rst_e",    32'(lcd_if.e), 32'd0);
    check("rst_rs",   32'(lcd_if.rs), 32'd0);
    check("rst_rw",   32'(lcd_if.rw), 32'd0);
    check("rst_data", 32'(lcd_if.lcd_data), 32'h00);

    // A request during power-up must be ignored.
    @(negedge clk);
    rst = 1'b0;
    n = 0; busy_low = 0;
    while (lcd_if.e !== 1'b1 && n < PWR + 100) begin
      lcd_if.lcd_enable = (n == 100);
      lcd_if.lcd_bus    = 10'h246;
      @(negedge clk);
      n++;
      if (lcd_if.busy !== 1'b1) busy_low++;
    end
    lcd_if.lcd_enable = 1'b0;
    check("pwr_first_rise", 32'(n), 32'(PWR + U));
    check("pwr_busy_low",   32'(busy_low), 32'd0);

    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        wait_e(1'b1, LONG + 100, n);
        check($sformatf("init%0d_gap", i), 32'(n),
              32'(((init_cmds[i-1] == 8'h01) ? LONG : SHORT) - E_HIGH));
      end
      check($sformatf("init%0d_data", i), 32'(lcd_if.lcd_data), 32'(init_cmds[i]));
      check($sformatf("init%0d_rs", i),   32'(lcd_if.rs), 32'd0);
      check($sformatf("init%0d_rw", i),   32'(lcd_if.rw), 32'd0);
      wait_e(1'b0, 100, n);
      check($sformatf("init%0d_high", i), 32'(n), 32'(E_HIGH));
    end
    n = 0;
    while (lcd_if.busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("init_to_ready", 32'(n), 32'(SHORT - 14 * U));
    repeat (3) @(negedge clk);
    check("ready_busy", 32'(lcd_if.busy), 32'd0);
    check("ready_e",    32'(lcd_if.e), 32'd0);

    xfer(10'b10_0100_0110, SHORT, "char_F");
    xfer(10'b00_0000_0001, LONG,  "clear");
    xfer(10'b01_0000_0010, LONG,  "home_rw");
    xfer(10'b10_0000_0001, SHORT, "data_01");

    // Requests during SEND and on its final edge are dropped; the next one lands.
    @(negedge clk);
    lcd_if.lcd_enable = 1'b1;
    lcd_if.lcd_bus    = 10'b10_0100_0001;
    @(negedge clk);
    lcd_if.lcd_enable = 1'b0;
    n = 0; rises = 0; prev_e = 1'b0;
    while (n < SHORT) begin
      @(negedge clk);
      n++;
      if (lcd_if.e === 1'b1 && prev_e !== 1'b1) rises++;
      prev_e = lcd_if.e;
      lcd_if.lcd_enable = (n == 5) || (n == SHORT - 1);
      lcd_if.lcd_bus    = (n == 5) ? 10'b10_0101_1010 : 10'b10_0110_0110;
    end
    check("ign_busy_at_exit", 32'(lcd_if.busy), 32'd0);
    check("ign_data_kept",    32'(lcd_if.lcd_data), 32'h41);
    check("ign_one_pulse",    32'(rises), 32'd1);
    lcd_if.lcd_enable = 1'b1;
    lcd_if.lcd_bus    = 10'b10_0100_0010;
    @(negedge clk);
    lcd_if.lcd_enable = 1'b0;
    check("next_accept_busy", 32'(lcd_if.busy), 32'd1);
    check("next_accept_data", 32'(lcd_if.lcd_data), 32'h42);
    n = 0;
    while (lcd_if.busy === 1'b1 && n < SHORT + 100) begin
      @(negedge clk);
      n++;
    end
    check("next_window", 32'(n), 32'(SHORT));

    // Reset in the middle of an e pulse.
    @(negedge clk);
    lcd_if.lcd_enable = 1'b1;
    lcd_if.lcd_bus    = 10'b10_0101_0111;
    @(negedge clk);
    lcd_if.lcd_enable = 1'b0;
    wait_e(1'b1, 100, n);
    check("abort_e_seen", 32'(lcd_if.e), 32'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_e",    32'(lcd_if.e), 32'd0);
    check("abort_busy", 32'(lcd_if.busy), 32'd1);
    check("abort_rs",   32'(lcd_if.rs), 32'd0);
    check("abort_data", 32'(lcd_if.lcd_data), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      lcd_if.lcd_enable = (i == 10);
      @(negedge clk);
      if (lcd_if.e !== 1'b0 || lcd_if.busy !== 1'b1 || lcd_if.lcd_data !== 8'h00) bad++;
    end
    lcd_if.lcd_enable = 1'b0;
    check("abort_powerup_restart", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
